// File: rtl/simd_fir_engine_if.sv
// Stream and coefficient-write bus of the SIMD FIR engine.
// master = producer/consumer/coefficient loader, slave = the engine.
interface simd_fir_engine_if #(
   parameter int LANES = 8,
   parameter int DW    = 16,
   parameter int TAPS  = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*DW-1:0]      in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*DW-1:0]      out_data;
   logic                     coef_we;
   logic [$clog2(TAPS)-1:0]  coef_addr;
   logic [DW-1:0]            coef_data;

   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/simd_fir_engine.sv
// Multi-lane FIR engine: per-lane delay lines, one shared coefficient bank,
// time-multiplexed MAC over N taps, then round and saturate/wrap per lane.
module simd_fir_engine #(
   parameter int LANES = 8,
   parameter int DW    = 16,
   parameter int TAPS  = 32,
   parameter int ACCW  = 40,
   parameter int FRAC  = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [$clog2(TAPS):0]   cfg_taps_i,
   input  logic                    sat_en_i,
   input  logic                    flush_i,
   output logic                    busy_o,
   simd_fir_engine_if.slave        bus
);
   localparam int TW = $clog2(TAPS);

   localparam logic signed [ACCW-1:0] HALF = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_e;

   state_e                 state_q, state_d;
   logic [TW-1:0]          k_q;
   logic [TW:0]            n_q;
   logic [TW:0]            n_clamped;
   logic                   sat_q;
   logic signed [DW-1:0]   coef_q [TAPS];
   logic signed [DW-1:0]   c_k;
   logic                   in_idle;
   logic                   accept;
   logic                   last_tap;

   assign in_idle  = (state_q == S_IDLE);
   assign accept   = in_idle && bus.in_valid;
   assign last_tap = ({1'b0, k_q} == (n_q - 1'b1));
   assign c_k      = coef_q[k_q];

   assign bus.in_ready  = in_idle;
   assign bus.out_valid = (state_q == S_OUT);
   assign busy_o        = !in_idle;

   always_comb begin
      n_clamped = cfg_taps_i;
      if (cfg_taps_i == '0)
         n_clamped = (TW+1)'(1);
      else if (cfg_taps_i > (TW+1)'(TAPS))
         n_clamped = (TW+1)'(TAPS);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)        state_d = S_MAC;
         S_MAC:   if (last_tap)      state_d = S_ROUND;
         S_ROUND:                    state_d = S_OUT;
         S_OUT:   if (bus.out_ready) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q   <= '0;
         n_q   <= '0;
         sat_q <= 1'b0;
      end else if (accept) begin
         k_q   <= '0;
         n_q   <= n_clamped;
         sat_q <= sat_en_i;
      end else if (state_q == S_MAC) begin
         k_q   <= k_q + 1'b1;
      end
   end

   // Range check matters only when TAPS is not a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < TAPS; k++)
            coef_q[k] <= '0;
      end else if (in_idle && bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
         coef_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DW-1:0]     x_q [TAPS];
      logic signed [ACCW-1:0]   acc_q;
      logic signed [2*DW-1:0]   prod;
      logic signed [ACCW-1:0]   sum;
      logic signed [ACCW-1:0]   rnd;
      logic [DW-1:0]            res;
      logic [DW-1:0]            out_q;

      assign prod = c_k * x_q[k_q];
      assign sum  = acc_q + HALF;
      assign rnd  = sum >>> FRAC;

      always_comb begin
         res = rnd[DW-1:0];
         if (sat_q) begin
            if (rnd > MAXV)
               res = MAXV[DW-1:0];
            else if (rnd < MINV)
               res = MINV[DW-1:0];
         end
      end

      // Flush beats an accept in the same cycle: history zeroed, x[0] still loads.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 0; k < TAPS; k++)
               x_q[k] <= '0;
            acc_q <= '0;
            out_q <= '0;
         end else begin
            if (accept) begin
               for (int k = 1; k < TAPS; k++)
                  x_q[k] <= flush_i ? '0 : x_q[k-1];
               x_q[0] <= bus.in_data[gi*DW +: DW];
            end else if (in_idle && flush_i) begin
               for (int k = 0; k < TAPS; k++)
                  x_q[k] <= '0;
            end

            if (accept)
               acc_q <= '0;
            else if (state_q == S_MAC)
               acc_q <= acc_q + ACCW'(prod);

            if (state_q == S_ROUND)
               out_q <= res;
         end
      end

      assign bus.out_data[gi*DW +: DW] = out_q;
   end
endmodule
